// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - shared types and hash constants for the Bloom-filter unit
package ibex_pkg;

    typedef enum logic [1:0] {
        BLOOM_INSERT = 2'b00,
        BLOOM_QUERY  = 2'b01,
        BLOOM_CLEAR  = 2'b10,
        BLOOM_COUNT  = 2'b11
    } bloom_op_e;

    typedef enum logic [1:0] {
        BLOOM_IDLE,
        BLOOM_PROBE,
        BLOOM_CLR,
        BLOOM_DONE
    } bloom_state_e;

    // Multiplicative hash constants (golden-ratio and murmur-style mixers).
    localparam logic [31:0] BloomMulA = 32'h9E3779B1;
    localparam logic [31:0] BloomMulB = 32'h85EBCA6B;

endpackage

// File: rtl/ibex_bloom_hash.sv
// rtl/ibex_bloom_hash.sv - double-hashing probe index generator (combinational)
module ibex_bloom_hash
    import ibex_pkg::*;
#(
    parameter int NumBits = 1024
) (
    input  logic [31:0]                  i_key,
    input  logic [2:0]                   i_k,
    output logic [$clog2(NumBits)-1:0]   o_idx
);

    localparam int IdxW = $clog2(NumBits);

    logic [31:0]     w_prod_a;
    logic [31:0]     w_prod_b;
    logic [IdxW-1:0] w_h1;
    logic [IdxW-1:0] w_h2;
    logic [IdxW-1:0] w_step;

    // Top IdxW bits of each truncated product are the best-mixed bits.
    // h2 is forced odd so successive probes walk the whole power-of-two array.
    assign w_prod_a = i_key * BloomMulA;
    assign w_prod_b = i_key * BloomMulB;
    assign w_h1     = w_prod_a[31 -: IdxW];
    assign w_h2     = w_prod_b[31 -: IdxW] | IdxW'(1);
    assign w_step   = w_h2 * IdxW'(i_k);
    assign o_idx    = w_h1 + w_step;

endmodule

// File: rtl/ibex_bloom_unit.sv
// rtl/ibex_bloom_unit.sv - multi-cycle Bloom-filter accelerator for the EX stage
module ibex_bloom_unit
    import ibex_pkg::*;
#(
    parameter int NumBits    = 1024,
    parameter int NumHashes  = 3,
    parameter int NumFilters = 2,
    parameter int CntW       = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] key_i,
    input  logic [31:0] sel_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] result_o
);

    localparam int IdxW  = $clog2(NumBits);
    localparam int Words = NumBits / 32;
    localparam int FSelW = (NumFilters > 1) ? $clog2(NumFilters) : 1;
    localparam int WordW = (Words > 1) ? $clog2(Words) : 1;
    localparam int CtrW  = (WordW > 3) ? WordW : 3;

    bloom_state_e          r_state;
    bloom_state_e          w_state_next;
    bloom_op_e             r_op;
    logic [31:0]           r_key;
    logic [FSelW-1:0]      r_sel;
    logic [CtrW-1:0]       r_cnt;
    logic                  r_all_set;
    logic [31:0]           r_result;
    logic [NumBits-1:0]    r_bits  [NumFilters];
    logic [CntW-1:0]       r_count [NumFilters];

    logic [FSelW-1:0]      w_sel_in;
    logic [IdxW-1:0]       w_idx;
    logic                  w_bit;
    logic                  w_last_probe;
    logic                  w_last_word;
    logic                  w_unused_sel;

    assign w_sel_in     = (NumFilters == 1) ? '0 : sel_i[FSelW-1:0];
    assign w_unused_sel = ^sel_i;
    assign w_bit        = r_bits[r_sel][w_idx];
    assign w_last_probe = (r_cnt == CtrW'(NumHashes - 1));
    assign w_last_word  = (r_cnt == CtrW'(Words - 1));

    ibex_bloom_hash #(
        .NumBits (NumBits)
    ) u_hash (
        .i_key (r_key),
        .i_k   (r_cnt[2:0]),
        .o_idx (w_idx)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= BLOOM_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic; starts are only honoured in IDLE, QUERY leaves on the first clear bit.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BLOOM_IDLE: begin
                if (en_i) begin
                    case (bloom_op_e'(op_i))
                        BLOOM_INSERT, BLOOM_QUERY: w_state_next = BLOOM_PROBE;
                        BLOOM_CLEAR:               w_state_next = BLOOM_CLR;
                        default:                   w_state_next = BLOOM_DONE;
                    endcase
                end
            end
            BLOOM_PROBE: begin
                if (w_last_probe || (r_op == BLOOM_QUERY && !w_bit)) w_state_next = BLOOM_DONE;
            end
            BLOOM_CLR: begin
                if (w_last_word) w_state_next = BLOOM_DONE;
            end
            default: w_state_next = BLOOM_IDLE;
        endcase
    end

    // Operand latching, probe/word counter and result register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_op      <= BLOOM_INSERT;
            r_key     <= '0;
            r_sel     <= '0;
            r_cnt     <= '0;
            r_all_set <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                BLOOM_IDLE: begin
                    if (en_i) begin
                        r_op      <= bloom_op_e'(op_i);
                        r_key     <= key_i;
                        r_sel     <= w_sel_in;
                        r_cnt     <= '0;
                        r_all_set <= 1'b1;
                        r_result  <= 32'(r_count[w_sel_in]);
                    end
                end
                BLOOM_PROBE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_op == BLOOM_INSERT) begin
                        r_all_set <= r_all_set & w_bit;
                        if (w_last_probe) r_result <= {31'b0, r_all_set & w_bit};
                    end else if (!w_bit) begin
                        r_result <= '0;
                    end else if (w_last_probe) begin
                        r_result <= 32'd1;
                    end
                end
                BLOOM_CLR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last_word) r_result <= '0;
                end
                default: ;
            endcase
        end
    end

    // Filter bit arrays and saturating insert counters; only the latched filter is touched.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int f = 0; f < NumFilters; f++) begin
                r_bits[f]  <= '0;
                r_count[f] <= '0;
            end
        end else if (r_state == BLOOM_PROBE && r_op == BLOOM_INSERT) begin
            r_bits[r_sel][w_idx] <= 1'b1;
            if (w_last_probe && r_count[r_sel] != {CntW{1'b1}}) begin
                r_count[r_sel] <= r_count[r_sel] + 1'b1;
            end
        end else if (r_state == BLOOM_CLR) begin
            r_bits[r_sel][int'(r_cnt) * 32 +: 32] <= '0;
            if (w_last_word) r_count[r_sel] <= '0;
        end
    end

    assign busy_o   = (r_state != BLOOM_IDLE);
    assign valid_o  = (r_state == BLOOM_DONE);
    assign result_o = valid_o ? r_result : 32'd0;

endmodule

// File: tb/tb_ibex_bloom_unit.sv
// tb/tb_ibex_bloom_unit.sv - directed self-checking bench for ibex_bloom_unit
module tb_ibex_bloom_unit;
    import ibex_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  op;
    logic [31:0] key;
    logic [31:0] sel;
    logic        busy, valid, busy2, valid2;
    logic [31:0] result, result2;

    int          n_cmp = 0;
    int          n_err = 0;
    int          lat;
    int          npulse;
    logic [31:0] res, res2;
    logic        busy_ok;

    always #5 clk = ~clk;

    ibex_bloom_unit dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .op_i(op), .key_i(key), .sel_i(sel),
        .busy_o(busy), .valid_o(valid), .result_o(result)
    );

    ibex_bloom_unit #(.CntW(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .op_i(op), .key_i(key), .sel_i(sel),
        .busy_o(busy2), .valid_o(valid2), .result_o(result2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for valid; lat counts cycles after acceptance.
    task automatic run_op(input logic [1:0] o, input logic [31:0] k, input logic [31:0] s);
        @(negedge clk);
        en = 1'b1; op = o; key = k; sel = s;
        @(negedge clk);
        en = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!valid && lat < 100) begin
            busy_ok &= busy;
            @(negedge clk);
            lat++;
        end
        busy_ok &= busy;
        res  = result;
        res2 = result2;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; op = 2'b00; key = '0; sel = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy",   {31'b0, busy},  32'd0);
        check("reset_valid",  {31'b0, valid}, 32'd0);
        check("reset_result", result,         32'd0);

        run_op(BLOOM_QUERY, 32'h1234, 32'd0);
        check("q_empty_lat", lat, 32'd2);
        check("q_empty_res", res, 32'd0);

        run_op(BLOOM_INSERT, 32'h1234, 32'd0);
        check("ins1_lat",  lat, 32'd4);
        check("ins1_res",  res, 32'd0);
        check("ins1_busy", {31'b0, busy_ok}, 32'd1);
        @(negedge clk);
        check("post_valid",  {31'b0, valid}, 32'd0);
        check("post_busy",   {31'b0, busy},  32'd0);
        check("post_result", result,         32'd0);

        run_op(BLOOM_QUERY, 32'h1234, 32'd0);
        check("q_hit_lat", lat, 32'd4);
        check("q_hit_res", res, 32'd1);

        run_op(BLOOM_INSERT, 32'h1234, 32'd0);
        check("ins2_lat", lat, 32'd4);
        check("ins2_res", res, 32'd1);

        run_op(BLOOM_QUERY, 32'h1234, 32'd1);
        check("q_f1_lat", lat, 32'd2);
        check("q_f1_res", res, 32'd0);

        run_op(BLOOM_COUNT, 32'h0, 32'd1);
        check("cnt_f1_lat", lat, 32'd1);
        check("cnt_f1_res", res, 32'd0);

        run_op(BLOOM_COUNT, 32'h0, 32'd0);
        check("cnt_f0_lat", lat, 32'd1);
        check("cnt_f0_res", res, 32'd2);

        run_op(BLOOM_INSERT, 32'h1234, 32'd1);
        check("ins_f1_res", res, 32'd0);

        for (int i = 1; i <= 5; i++) begin
            run_op(BLOOM_INSERT, 32'h5000_0000 + 32'(i * 7), 32'd0);
            check("ins5_lat", lat, 32'd4);
        end
        run_op(BLOOM_COUNT, 32'h0, 32'd0);
        check("cnt7_res",     res,  32'd7);
        check("cnt_sat_res2", res2, 32'd3);

        run_op(BLOOM_CLEAR, 32'h0, 32'd0);
        check("clr_lat",  lat, 32'd33);
        check("clr_res",  res, 32'd0);
        check("clr_busy", {31'b0, busy_ok}, 32'd1);

        run_op(BLOOM_COUNT, 32'h0, 32'd0);
        check("cnt_clr_res",  res,  32'd0);
        check("cnt_clr_res2", res2, 32'd0);

        for (int i = 1; i <= 5; i++) begin
            run_op(BLOOM_QUERY, 32'h5000_0000 + 32'(i * 7), 32'd0);
            check("q_clr_lat", lat, 32'd2);
            check("q_clr_res", res, 32'd0);
        end
        run_op(BLOOM_QUERY, 32'h1234, 32'd0);
        check("q_clr_1234", res, 32'd0);

        run_op(BLOOM_QUERY, 32'h1234, 32'd1);
        check("q_f1_kept_lat", lat, 32'd4);
        check("q_f1_kept_res", res, 32'd1);
        run_op(BLOOM_COUNT, 32'h0, 32'd1);
        check("cnt_f1_kept", res, 32'd1);

        @(negedge clk);
        en = 1'b1; op = BLOOM_INSERT; key = 32'hABCD; sel = 32'd1;
        npulse = 0;
        lat = 0;
        res = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (valid) begin
                npulse++;
                lat = c;
                res = result;
            end
            op  = c[1:0];
            key = 32'h1234 + 32'(c);
            en  = (lat == 0);
        end
        en = 1'b0;
        check("cont_pulses", npulse, 32'd1);
        check("cont_lat",    lat,    32'd4);
        check("cont_res",    res,    32'd0);

        run_op(BLOOM_QUERY, 32'hABCD, 32'd1);
        check("cont_q_abcd", res, 32'd1);
        run_op(BLOOM_QUERY, 32'h1234, 32'd1);
        check("cont_q_1234", res, 32'd1);
        run_op(BLOOM_COUNT, 32'h0, 32'd1);
        check("cont_cnt_f1", res, 32'd2);

        @(negedge clk);
        en = 1'b1; op = BLOOM_CLEAR; sel = 32'd1;
        @(negedge clk);
        en = 1'b0;
        check("rstclr_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstclr_valid", {31'b0, valid}, 32'd0);
        check("rstclr_idle",  {31'b0, busy},  32'd0);
        npulse = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid) npulse++;
        end
        check("rstclr_nopulse", npulse, 32'd0);

        run_op(BLOOM_COUNT, 32'h0, 32'd1);
        check("rst_cnt_f1", res, 32'd0);
        run_op(BLOOM_COUNT, 32'h0, 32'd0);
        check("rst_cnt_f0", res, 32'd0);
        run_op(BLOOM_QUERY, 32'hABCD, 32'd1);
        check("rst_q_lat", lat, 32'd2);
        check("rst_q_res", res, 32'd0);
        run_op(BLOOM_QUERY, 32'h1234, 32'd1);
        check("rst_q_1234", res, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
